// File: rtl/clint_pkg.sv
// Shared CLINT register offsets, cause codes and the address decoder used by clint_mhart.
package clint_pkg;

  localparam logic [31:0] MSIP_OFS     = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_OFS = 32'h0000_4000;
  localparam logic [31:0] MTIME_OFS    = 32'h0000_BFF8;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_MSIP,
    REG_CMP_LO,
    REG_CMP_HI,
    REG_TIME_LO,
    REG_TIME_HI
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e  kind;
    logic [2:0] hart;
  } reg_sel_t;

  // Addresses below the base wrap to huge offsets and so fall out of every window.
  function automatic reg_sel_t decode_addr(input logic [31:0] addr, input logic [31:0] base,
                                           input int harts, input logic msip_en);
    logic [31:0] ofs;
    logic [31:0] rel;
    reg_sel_t    sel;
    ofs      = addr - base;
    sel.kind = REG_NONE;
    sel.hart = '0;
    if (ofs[1:0] == 2'b00) begin
      rel = ofs - MSIP_OFS;
      if (msip_en && rel < 32'(4 * harts)) begin
        sel.kind = REG_MSIP;
        sel.hart = rel[4:2];
      end
      rel = ofs - MTIMECMP_OFS;
      if (rel < 32'(8 * harts)) begin
        sel.kind = rel[2] ? REG_CMP_HI : REG_CMP_LO;
        sel.hart = rel[5:3];
      end
      if (ofs == MTIME_OFS)         sel.kind = REG_TIME_LO;
      if (ofs == MTIME_OFS + 32'd4) sel.kind = REG_TIME_HI;
    end
    return sel;
  endfunction

endpackage

// File: rtl/clint_timebase.sv
// Prescaler plus 64-bit mtime counter; a half-word write wins over a same-cycle tick.
module clint_timebase #(
  parameter logic [31:0] TICK_CNT = 32'd100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] mtime
);

  logic [31:0] prescale;
  logic        tick;

  assign tick = (prescale == TICK_CNT - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
      mtime    <= '0;
    end else begin
      prescale <= tick ? '0 : prescale + 32'd1;
      if (wr_lo)
        mtime[31:0] <= wdata;
      else if (wr_hi)
        mtime[63:32] <= wdata;
      else if (tick)
        mtime <= mtime + 64'd1;
    end
  end

endmodule

// File: rtl/clint_mhart.sv
// Multi-hart CLINT: msip (only with CLINT_MSIP_EN defined), mtimecmp, mtime and
// per-hart interrupt outputs behind a one-cycle registered read port.
module clint_mhart
  import clint_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          HART_NUMS = 1,
  parameter logic [31:0] TICK_CNT  = 32'd100
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RDEN,
  input  logic [31:0]            RIADDR,
  output logic [31:0]            ROADDR,
  output logic                   RVALID,
  output logic [31:0]            RDATA,
  input  logic                   WREN,
  input  logic [31:0]            WADDR,
  input  logic [31:0]            WDATA,
  output logic [HART_NUMS-1:0]   INT_EN,
  output logic [4*HART_NUMS-1:0] INT_CODE
);

  logic [HART_NUMS-1:0] msip;
  logic [HART_NUMS-1:0] mtip;
  logic [63:0]          mtimecmp [HART_NUMS];
  logic [63:0]          mtime;
  logic [31:0]          rd_val;
  logic                 rd_hit;
  reg_sel_t             rsel;
  reg_sel_t             wsel;

`ifdef CLINT_MSIP_EN
  localparam logic MSIP_EN = 1'b1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      msip <= '0;
    end else begin
      for (int h = 0; h < HART_NUMS; h++)
        if (WREN && wsel.kind == REG_MSIP && wsel.hart == 3'(h))
          msip[h] <= WDATA[0];
    end
  end
`else
  localparam logic MSIP_EN = 1'b0;

  assign msip = '0;
`endif

  assign rsel   = decode_addr(RIADDR, BASE_ADDR, HART_NUMS, MSIP_EN);
  assign wsel   = decode_addr(WADDR, BASE_ADDR, HART_NUMS, MSIP_EN);
  assign rd_hit = RDEN && (rsel.kind != REG_NONE);

  clint_timebase #(
    .TICK_CNT(TICK_CNT)
  ) u_timebase (
    .clk   (CLK),
    .rst_n (RST),
    .wr_lo (WREN && wsel.kind == REG_TIME_LO),
    .wr_hi (WREN && wsel.kind == REG_TIME_HI),
    .wdata (WDATA),
    .mtime (mtime)
  );

  // mtip compares the registered operands, so it trails any change by one cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mtip <= '0;
      for (int h = 0; h < HART_NUMS; h++)
        mtimecmp[h] <= '1;
    end else begin
      for (int h = 0; h < HART_NUMS; h++) begin
        mtip[h] <= (mtime >= mtimecmp[h]);
        if (WREN && wsel.hart == 3'(h)) begin
          if (wsel.kind == REG_CMP_LO) mtimecmp[h][31:0]  <= WDATA;
          if (wsel.kind == REG_CMP_HI) mtimecmp[h][63:32] <= WDATA;
        end
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int h = 0; h < HART_NUMS; h++) begin
      if (rsel.hart == 3'(h)) begin
        case (rsel.kind)
          REG_MSIP:   rd_val = {31'b0, msip[h]};
          REG_CMP_LO: rd_val = mtimecmp[h][31:0];
          REG_CMP_HI: rd_val = mtimecmp[h][63:32];
          default:    ;
        endcase
      end
    end
    if (rsel.kind == REG_TIME_LO) rd_val = mtime[31:0];
    if (rsel.kind == REG_TIME_HI) rd_val = mtime[63:32];
  end

  // Missed reads leave address and data untouched.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RVALID <= 1'b0;
      ROADDR <= '0;
      RDATA  <= '0;
    end else begin
      RVALID <= rd_hit;
      if (rd_hit) begin
        ROADDR <= RIADDR;
        RDATA  <= rd_val;
      end
    end
  end

  always_comb begin
    INT_EN   = '0;
    INT_CODE = '0;
    for (int h = 0; h < HART_NUMS; h++) begin
      INT_EN[h] = msip[h] | mtip[h];
      if (msip[h])
        INT_CODE[4*h +: 4] = CAUSE_MSI;
      else if (mtip[h])
        INT_CODE[4*h +: 4] = CAUSE_MTI;
    end
  end

endmodule

// File: tb/tb_clint_mhart.sv
// Scoreboard bench for clint_mhart (2 harts, TICK_CNT=4); set CLINT_MSIP_EN to match the DUT build.
module tb_clint_mhart;

  localparam logic [31:0] BASE  = 32'h0200_0000;
  localparam int          H     = 2;
  localparam int          T     = 4;
`ifdef CLINT_MSIP_EN
  localparam bit          MSIP_ON = 1'b1;
`else
  localparam bit          MSIP_ON = 1'b0;
`endif

  localparam logic [31:0] A_MSIP0   = BASE + 32'h0000;
  localparam logic [31:0] A_MSIP2   = BASE + 32'h0008;
  localparam logic [31:0] A_CMP0_LO = BASE + 32'h4000;
  localparam logic [31:0] A_CMP0_HI = BASE + 32'h4004;
  localparam logic [31:0] A_CMP1_LO = BASE + 32'h4008;
  localparam logic [31:0] A_CMP1_HI = BASE + 32'h400C;
  localparam logic [31:0] A_CMP2_LO = BASE + 32'h4010;
  localparam logic [31:0] A_CMP2_HI = BASE + 32'h4014;
  localparam logic [31:0] A_T_LO    = BASE + 32'hBFF8;
  localparam logic [31:0] A_T_HI    = BASE + 32'hBFFC;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         RDEN = 1'b0;
  logic [31:0]  RIADDR = '0;
  logic [31:0]  ROADDR;
  logic         RVALID;
  logic [31:0]  RDATA;
  logic         WREN = 1'b0;
  logic [31:0]  WADDR = '0;
  logic [31:0]  WDATA = '0;
  logic [H-1:0] INT_EN;
  logic [4*H-1:0] INT_CODE;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         rvalid;
    logic [31:0]  roaddr;
    logic [31:0]  rdata;
    logic [H-1:0] int_en;
    logic [4*H-1:0] int_code;
  } exp_t;

  exp_t sb[$];

  // Reference state: the architectural registers as plain numbers.
  logic [63:0] m_time;
  logic [63:0] m_cmp [H];
  logic [H-1:0] m_msip;
  logic [H-1:0] m_mtip;
  int          m_phase;
  logic [31:0] m_roaddr;
  logic [31:0] m_rdata;

  logic [31:0] ofs_tab [13] = '{32'h0, 32'h4, 32'h8, 32'h4000, 32'h4004, 32'h4008, 32'h400C,
                                32'h4010, 32'hBFF8, 32'hBFFC, 32'hBFF4, 32'hC000, 32'h2};

  clint_mhart #(
    .BASE_ADDR(BASE),
    .HART_NUMS(H),
    .TICK_CNT (32'(T))
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .RDEN    (RDEN),
    .RIADDR  (RIADDR),
    .ROADDR  (ROADDR),
    .RVALID  (RVALID),
    .RDATA   (RDATA),
    .WREN    (WREN),
    .WADDR   (WADDR),
    .WDATA   (WDATA),
    .INT_EN  (INT_EN),
    .INT_CODE(INT_CODE)
  );

  always #5 CLK = ~CLK;

  // 0 none, 1 msip, 2 mtimecmp lo, 3 mtimecmp hi, 4 mtime lo, 5 mtime hi
  function automatic int reg_id(input logic [31:0] a, output int hart);
    logic [31:0] o;
    o    = a - BASE;
    hart = 0;
    if (o % 4 != 0) return 0;
    if (MSIP_ON && o < 4 * H) begin
      hart = int'(o / 4);
      return 1;
    end
    if (o >= 32'h4000 && o < 32'h4000 + 8 * H) begin
      hart = int'((o - 32'h4000) / 8);
      return ((o - 32'h4000) % 8 == 0) ? 2 : 3;
    end
    if (o == 32'hBFF8) return 4;
    if (o == 32'hBFFC) return 5;
    return 0;
  endfunction

  task automatic model_reset();
    m_time   = '0;
    m_phase  = 0;
    m_msip   = '0;
    m_mtip   = '0;
    m_roaddr = '0;
    m_rdata  = '0;
    for (int h = 0; h < H; h++) m_cmp[h] = '1;
  endtask

  // Advance the reference by one clock edge using the inputs now on the pins.
  task automatic model_step();
    exp_t        e;
    int          rk, rh, wk, wh;
    logic [31:0] rv;
    logic [H-1:0] nmtip;
    bit          tick;
    if (!RST) begin
      model_reset();
    end else begin
      rk = reg_id(RIADDR, rh);
      rv = '0;
      case (rk)
        1: rv = {31'b0, m_msip[rh]};
        2: rv = m_cmp[rh][31:0];
        3: rv = m_cmp[rh][63:32];
        4: rv = m_time[31:0];
        5: rv = m_time[63:32];
        default: rv = '0;
      endcase
      e.rvalid = RDEN && rk != 0;
      if (e.rvalid) begin
        m_roaddr = RIADDR;
        m_rdata  = rv;
      end
      for (int h = 0; h < H; h++) nmtip[h] = (m_time >= m_cmp[h]);
      tick    = (m_phase == T - 1);
      m_phase = tick ? 0 : m_phase + 1;
      wk = WREN ? reg_id(WADDR, wh) : 0;
      case (wk)
        1: m_msip[wh] = WDATA[0];
        2: m_cmp[wh]  = {m_cmp[wh][63:32], WDATA};
        3: m_cmp[wh]  = {WDATA, m_cmp[wh][31:0]};
        4: m_time     = {m_time[63:32], WDATA};
        5: m_time     = {WDATA, m_time[31:0]};
        default: ;
      endcase
      if (wk != 4 && wk != 5 && tick) m_time = m_time + 64'd1;
      m_mtip = nmtip;
    end
    if (!RST) e.rvalid = 1'b0;
    e.roaddr = m_roaddr;
    e.rdata  = m_rdata;
    for (int h = 0; h < H; h++) begin
      e.int_en[h] = m_msip[h] | m_mtip[h];
      e.int_code[4*h +: 4] = m_msip[h] ? 4'd3 : (m_mtip[h] ? 4'd7 : 4'd0);
    end
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input logic rst, input logic rd, input logic [31:0] ra,
                                input logic wr, input logic [31:0] wa, input logic [31:0] wd);
    @(negedge CLK);
    RST    = rst;
    RDEN   = rd;
    RIADDR = ra;
    WREN   = wr;
    WADDR  = wa;
    WDATA  = wd;
    model_step();
  endtask

  task automatic idle();
    apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic rd(input logic [31:0] a);
    apply_stimulus(1'b1, 1'b1, a, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    apply_stimulus(1'b1, 1'b0, '0, 1'b1, a, d);
  endtask

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_output(input exp_t e);
    compare("rvalid", 32'(RVALID), 32'(e.rvalid));
    compare("roaddr", ROADDR, e.roaddr);
    compare("rdata", RDATA, e.rdata);
    compare("int_en", 32'(INT_EN), 32'(e.int_en));
    compare("int_code", 32'(INT_CODE), 32'(e.int_code));
  endtask

  // Monitor: one expectation per clock edge, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra, wa;
    model_reset();
    repeat (3) apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);

    // Release, then read mtime lo on the 4th, 8th and 12th cycle after release.
    for (int n = 1; n <= 12; n++)
      apply_stimulus(1'b1, (n % 4 == 0), A_T_LO, 1'b0, '0, '0);

    // Hart 1 compare at 5, hart 0 left at all-ones.
    wr(A_CMP1_LO, 32'd5);
    wr(A_CMP1_HI, 32'd0);
    for (int i = 0; i < 30; i++) rd((i % 2 == 0) ? A_T_LO : A_CMP1_LO);

    // Hart index 2 is outside the window.
    rd(A_CMP2_LO);
    rd(A_CMP2_HI);
    rd(A_MSIP2);
    wr(A_CMP2_LO, 32'd0);
    wr(A_MSIP2, 32'd1);
    rd(A_CMP0_LO);
    rd(A_CMP0_HI);
    rd(A_CMP1_LO);
    rd(A_CMP1_HI);
    rd(A_MSIP0);
    rd(A_MSIP0 + 32'd4);

    // Timer pending on hart 0, then software interrupt on and off.
    wr(A_CMP0_LO, 32'd0);
    wr(A_CMP0_HI, 32'd0);
    idle();
    idle();
    wr(A_MSIP0, 32'd1);
    rd(A_MSIP0);
    idle();
    wr(A_MSIP0, 32'd0);
    rd(A_MSIP0);
    idle();

    // mtime lo write landing on a tick, then the carry on the next tick.
    for (int i = 0; i < 8 && m_phase != T - 1; i++) idle();
    wr(A_T_LO, 32'hFFFF_FFFF);
    rd(A_T_LO);
    rd(A_T_HI);
    for (int i = 0; i < 8 && m_phase != T - 1; i++) idle();
    idle();
    rd(A_T_LO);
    rd(A_T_HI);

    // Full 64-bit wrap.
    wr(A_T_HI, 32'hFFFF_FFFF);
    wr(A_T_LO, 32'hFFFF_FFFF);
    for (int i = 0; i < T + 1; i++) rd((i % 2 == 0) ? A_T_LO : A_T_HI);

    // Same-register read and write in one cycle returns the old value.
    apply_stimulus(1'b1, 1'b1, A_CMP1_LO, 1'b1, A_CMP1_LO, 32'h1234_5678);
    rd(A_CMP1_LO);

    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? $urandom : BASE + ofs_tab[$urandom_range(0, 12)];
      wa = ($urandom_range(0, 3) == 0) ? ra : BASE + ofs_tab[$urandom_range(0, 12)];
      apply_stimulus(1'b1, 1'($urandom_range(0, 1)), ra, ($urandom_range(0, 3) == 0),
                     wa, ($urandom_range(0, 1) == 0) ? $urandom_range(0, 40) : $urandom);
    end

    // Reset asserted while a read is in flight.
    @(negedge CLK);
    RDEN   = 1'b1;
    RIADDR = A_T_LO;
    WREN   = 1'b0;
    #2;
    RST = 1'b0;
    model_step();
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0, '0);
    idle();
    idle();
    rd(A_CMP0_HI);
    idle();

    @(posedge CLK);
    #3;
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clint_mhart.md
CLINT_MHART -- requirements
Module: clint_mhart

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0200_0000, register window base.
REQ-002 SHALL have parameter HART_NUMS, default 1, number of harts (legal 1..8).
REQ-003 SHALL have parameter TICK_CNT, default 32'd100, CLK cycles per mtime increment (legal >=1).
REQ-004 SHALL have CLK  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have RST  input  1  asynchronous, active-low reset.
REQ-006 SHALL have RDEN  input  1  read request.
REQ-007 SHALL have RIADDR  input  32  read address.
REQ-008 SHALL have ROADDR  output  32  address of the returned read data.
REQ-009 SHALL have RVALID  output  1  read data valid.
REQ-010 SHALL have RDATA  output  32  read data.
REQ-011 SHALL have WREN  input  1  write request, full 32-bit word.
REQ-012 SHALL have WADDR  input  32  write address.
REQ-013 SHALL have WDATA  input  32  write data.
REQ-014 SHALL have INT_EN  output  HART_NUMS  per-hart interrupt request.
REQ-015 SHALL have INT_CODE  output  4*HART_NUMS  per-hart cause code, hart h in bits [4h+3:4h].

Function
REQ-016 SHALL decode offsets: msip[h] at +0x0000+4h (bit 0 only); mtimecmp[h] lo/hi at +0x4000+8h / +0x4004+8h; mtime lo/hi at +0xBFF8 / +0xBFFC.
REQ-017 SHALL, on RDEN with a decoded RIADDR, assert RVALID for exactly one cycle on the following cycle, with ROADDR=RIADDR and RDATA=register value sampled at request cycle.
REQ-018 SHALL keep RVALID=0 for RDEN to undecoded addresses, including hart indices >=HART_NUMS; RDATA/ROADDR hold their prior values.
REQ-019 SHALL ignore WREN to undecoded addresses; decoded writes take effect on the next edge.
REQ-020 SHALL return the pre-write value when read and write hit the same register in the same cycle.
REQ-021 SHALL run a prescaler counting 0..TICK_CNT-1; on the cycle it equals TICK_CNT-1 it wraps to 0 and mtime increments by 1.
REQ-022 SHALL wrap mtime from 64'hFFFF_FFFF_FFFF_FFFF to 0 without a flag.
REQ-023 SHALL give an mtime half-write priority over a same-cycle tick; the unwritten half keeps its old value (no carry applied that cycle).
REQ-024 SHALL register mtip[h] = (mtime >= mtimecmp[h]), 64-bit unsigned, one cycle after the operands change.
REQ-025 SHALL drive INT_EN[h] = msip[h] | mtip[h] and INT_CODE[h] = 3 if msip[h], else 7 if mtip[h], else 0 (software over timer).
REQ-026 SHALL clear mtip[h] the cycle after a mtimecmp write makes mtimecmp[h] > mtime.

Reset
REQ-027 SHALL on RST low set: mtime=0, prescaler=0, all mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, mtip=0, RVALID=0, ROADDR=0, RDATA=0, INT_EN=0, INT_CODE=0.
REQ-028 SHALL discard any read in flight when reset asserts; RVALID stays 0 until a new request after release.

Configuration
REQ-029 SHALL compile msip registers only when CLINT_MSIP_EN is defined.
REQ-030 SHALL, without CLINT_MSIP_EN, leave msip offsets undecoded (RVALID=0, writes ignored) and tie msip terms to 0, so INT_CODE is only 7 or 0.

Structure
REQ-031 SHALL place offset constants (MSIP_OFS, MTIMECMP_OFS, MTIME_OFS) and cause codes (3, 7) in shared package clint_pkg.
REQ-032 SHALL implement prescaler plus mtime counter as sub-module clint_timebase, exporting mtime and accepting half-write strobes.

Verification
REQ-033 SHALL check TICK_CNT=4, reset release -> mtime reads 0,1,2 at cycles 4,8,12 after release; RVALID one cycle after RDEN.
REQ-034 SHALL check HART_NUMS=2, mtimecmp[1]=5, mtimecmp[0]=all-ones -> INT_EN=2'b10, INT_CODE[7:4]=7 one cycle after mtime reaches 5.
REQ-035 SHALL check CLINT_MSIP_EN: write 1 to BASE+0x0 while mtip[0]=1 -> INT_CODE[3:0]=3; write 0 -> 7.
REQ-036 SHALL check mtime lo write 32'hFFFF_FFFF coincident with tick -> lo=FFFF_FFFF, hi unchanged; next tick -> lo=0, hi+1.
REQ-037 SHALL check read BASE+0x4008 with HART_NUMS=1 -> RVALID stays 0; write there -> no register changes.
REQ-038 SHALL check RST low between RDEN and RVALID -> no RVALID, all outputs at reset values.
